// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper step/dir pulse generators.
// Holds the sequencer state encoding, default timing constants and width helpers.
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } step_state_e;

  // Defaults assume a 25 MHz clk_in: 2 us step high time, 1 us dir-to-step setup.
  localparam int DEFAULT_PULSE_WIDTH = 50;
  localparam int DEFAULT_DIR_SETUP   = 25;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Number of bits needed to hold the unsigned value 'value'.
  function automatic int bits_for(input int value);
    return (value < 2) ? 1 : $clog2(value + 1);
  endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// One step/dir channel: issues a counted burst of fixed-width step pulses at a
// programmable rise-to-rise period, with a direction setup delay and clean abort.
module step_pulse_gen
  import stepper_pkg::*;
#(
  parameter int COUNT_WIDTH  = 16,
  parameter int PERIOD_WIDTH = 16,
  parameter int PULSE_WIDTH  = DEFAULT_PULSE_WIDTH,
  parameter int DIR_SETUP    = DEFAULT_DIR_SETUP
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    start_in,
  input  logic                    abort_in,
  input  logic                    dir_in,
  input  logic [COUNT_WIDTH-1:0]  steps_in,
  input  logic [PERIOD_WIDTH-1:0] period_in,
  output logic                    step_out,
  output logic                    dir_out,
  output logic                    r_busy_out,
  output logic                    r_done_out,
  output logic [COUNT_WIDTH-1:0]  r_remaining_out
);

  // The single timer must hold the widest of: an unclamped period (one bit wider
  // than period_in so the 2*PULSE_WIDTH floor never truncates), and DIR_SETUP.
  localparam int TIMER_WIDTH = max_int(PERIOD_WIDTH + 1,
                                       max_int(bits_for(2 * PULSE_WIDTH), bits_for(DIR_SETUP)));

  localparam logic [TIMER_WIDTH-1:0] MIN_PERIOD  = TIMER_WIDTH'(2 * PULSE_WIDTH);
  localparam logic [TIMER_WIDTH-1:0] PULSE_TICKS = TIMER_WIDTH'(PULSE_WIDTH);
  localparam logic [TIMER_WIDTH-1:0] PULSE_LOAD  = TIMER_WIDTH'(PULSE_WIDTH - 1);
  localparam logic [TIMER_WIDTH-1:0] SETUP_LOAD  = (DIR_SETUP > 0) ? TIMER_WIDTH'(DIR_SETUP - 1) : '0;
  localparam bit                     SKIP_SETUP  = (DIR_SETUP == 0);

  step_state_e             state_q, state_d;
  logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
  logic [TIMER_WIDTH-1:0]  period_q, period_d;
  logic [COUNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic                    dir_q, dir_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    step_q, step_d;
  logic                    abort_pend_q, abort_pend_d;

  logic [TIMER_WIDTH-1:0]  period_ext;
  logic [TIMER_WIDTH-1:0]  gap_load;
  logic [COUNT_WIDTH-1:0]  remaining_dec;
  logic                    timer_expired;

  assign period_ext    = TIMER_WIDTH'(period_in);
  // Timer is loaded with N-1 so a phase lasts N cycles; GAP fills the rest of the period.
  assign gap_load      = period_q - PULSE_TICKS - TIMER_WIDTH'(1);
  assign remaining_dec = remaining_q - COUNT_WIDTH'(1);
  assign timer_expired = (timer_q == '0);

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    period_d     = period_q;
    remaining_d  = remaining_q;
    dir_d        = dir_q;
    done_d       = 1'b0;
    abort_pend_d = abort_pend_q;

    unique case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (!abort_in && start_in) begin
          if (steps_in == '0) begin
            done_d = 1'b1;
          end else begin
            dir_d       = dir_in;
            remaining_d = steps_in;
            period_d    = (period_ext > MIN_PERIOD) ? period_ext : MIN_PERIOD;
            if (SKIP_SETUP) begin
              state_d = ST_PULSE;
              timer_d = PULSE_LOAD;
            end else begin
              state_d = ST_SETUP;
              timer_d = SETUP_LOAD;
            end
          end
        end
      end

      ST_SETUP: begin
        if (abort_in) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (timer_expired) begin
          state_d = ST_PULSE;
          timer_d = PULSE_LOAD;
        end else begin
          timer_d = timer_q - TIMER_WIDTH'(1);
        end
      end

      ST_PULSE: begin
        // An abort during the pulse is remembered so the pulse is never cut short.
        abort_pend_d = abort_pend_q | abort_in;
        if (timer_expired) begin
          remaining_d = remaining_dec;
          if (remaining_dec == '0 || abort_pend_d) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GAP;
            timer_d = gap_load;
          end
        end else begin
          timer_d = timer_q - TIMER_WIDTH'(1);
        end
      end

      ST_GAP: begin
        if (abort_in) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (timer_expired) begin
          state_d = ST_PULSE;
          timer_d = PULSE_LOAD;
        end else begin
          timer_d = timer_q - TIMER_WIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they leave the chip registered.
    step_d = (state_d == ST_PULSE);
    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      period_q     <= '0;
      remaining_q  <= '0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      step_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      period_q     <= period_d;
      remaining_q  <= remaining_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      step_q       <= step_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign step_out        = step_q;
  assign dir_out         = dir_q;
  assign r_busy_out      = busy_q;
  assign r_done_out      = done_q;
  assign r_remaining_out = remaining_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen: a move-level model predicts step edges
// and done pulses; a monitor compares them against what the DUT presents.
module tb_step_pulse_gen;

  localparam int PW   = 4;
  localparam int DS   = 2;
  localparam int CW   = 16;
  localparam int PWID = 16;

  typedef enum {EV_RISE, EV_FALL, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       edge_no;
    bit       dir;
    int       rem;
    bit       busy;
  } ev_t;

  logic            clk_in = 1'b0;
  logic            reset_in = 1'b1;
  logic            start_in = 1'b0;
  logic            abort_in = 1'b0;
  logic            dir_in = 1'b0;
  logic [CW-1:0]   steps_in = '0;
  logic [PWID-1:0] period_in = '0;
  logic            step_out;
  logic            dir_out;
  logic            r_busy_out;
  logic            r_done_out;
  logic [CW-1:0]   r_remaining_out;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  mdl_dir = 1'b0;
  int  mdl_rem = 0;
  bit  prev_step = 1'b0;

  step_pulse_gen #(
    .COUNT_WIDTH (CW),
    .PERIOD_WIDTH(PWID),
    .PULSE_WIDTH (PW),
    .DIR_SETUP   (DS)
  ) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .start_in       (start_in),
    .abort_in       (abort_in),
    .dir_in         (dir_in),
    .steps_in       (steps_in),
    .period_in      (period_in),
    .step_out       (step_out),
    .dir_out        (dir_out),
    .r_busy_out     (r_busy_out),
    .r_done_out     (r_done_out),
    .r_remaining_out(r_remaining_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input ev_kind_e k, input int e, input bit d, input int r, input bit b);
    ev_t ev;
    ev.kind = k; ev.edge_no = e; ev.dir = d; ev.rem = r; ev.busy = b;
    exp_q.push_back(ev);
  endtask

  // Move-level model: rises at start + DS + k*max(period, 2*PW), each PW wide.
  // An abort sampled before a rise ends the move there; one sampled during a
  // pulse ends it when that pulse finishes.
  task automatic model_move(input int c, input int n, input int p, input bit d,
                            input int ab, output int end_e);
    int eff;
    int r;
    eff   = (p > 2 * PW) ? p : 2 * PW;
    end_e = c;
    if (n == 0) begin
      push(EV_DONE, c, mdl_dir, mdl_rem, 1'b0);
      return;
    end
    mdl_dir = d;
    for (int k = 0; k < n; k++) begin
      r = c + DS + k * eff;
      if (ab > 0 && ab <= r) begin
        push(EV_DONE, ab, d, n - k, 1'b0);
        mdl_rem = n - k;
        end_e   = ab;
        return;
      end
      push(EV_RISE, r, d, n - k, 1'b1);
      if ((ab > 0 && ab <= r + PW) || k == n - 1) begin
        push(EV_FALL, r + PW, d, n - k - 1, 1'b0);
        push(EV_DONE, r + PW, d, n - k - 1, 1'b0);
        mdl_rem = n - k - 1;
        end_e   = r + PW;
        return;
      end
      push(EV_FALL, r + PW, d, n - k - 1, 1'b1);
    end
  endtask

  task automatic consume(input ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_%s at edge %0d: got an event, expected none", k.name(), cyc);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", int'(k), int'(e.kind));
    check("event_edge", cyc, e.edge_no);
    check("dir_out", int'(dir_out), int'(e.dir));
    check("r_remaining_out", int'(r_remaining_out), e.rem);
    check("r_busy_out", int'(r_busy_out), int'(e.busy));
  endtask

  // Monitor: sampled on the falling edge, well away from the active edge.
  always @(negedge clk_in) begin
    if (reset_in) begin
      prev_step = step_out;
    end else begin
      if (step_out && !prev_step) consume(EV_RISE);
      if (!step_out && prev_step) consume(EV_FALL);
      if (r_done_out) consume(EV_DONE);
      prev_step = step_out;
    end
  end

  // Issues start for one cycle, records the prediction, then scrambles the
  // inputs that must be ignored while busy. Returns on the negedge after the start edge.
  task automatic begin_move(input int n, input int p, input bit d, input int ab_off,
                            input bit rel_reset, output int c, output int ab, output int end_e);
    @(negedge clk_in);
    if (rel_reset) reset_in = 1'b0;
    start_in  = 1'b1;
    dir_in    = d;
    steps_in  = CW'(n);
    period_in = PWID'(p);
    c  = cyc + 1;
    ab = (ab_off > 0) ? c + ab_off : 0;
    model_move(c, n, p, d, ab, end_e);
    @(negedge clk_in);
    start_in  = 1'b0;
    dir_in    = ~d;
    steps_in  = CW'($urandom);
    period_in = PWID'($urandom);
  endtask

  task automatic finish_move(input int ab, input int end_e);
    if (ab > 0) begin
      while (cyc < ab - 1) @(negedge clk_in);
      abort_in = 1'b1;
      @(negedge clk_in);
      abort_in = 1'b0;
    end
    while (cyc < end_e + 1) @(negedge clk_in);
  endtask

  task automatic run_move(input int n, input int p, input bit d, input int ab_off);
    int c, ab, end_e;
    begin_move(n, p, d, ab_off, 1'b0, c, ab, end_e);
    finish_move(ab, end_e);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_step_out"}, int'(step_out), 0);
    check({tag, "_dir_out"}, int'(dir_out), 0);
    check({tag, "_r_busy_out"}, int'(r_busy_out), 0);
    check({tag, "_r_done_out"}, int'(r_done_out), 0);
    check({tag, "_r_remaining_out"}, int'(r_remaining_out), 0);
  endtask

  initial begin
    int c, ab, end_e, n, p, eff, ab_off;
    bit d;

    repeat (3) @(negedge clk_in);
    check_reset_values("por");
    reset_in = 1'b0;

    // Basic move: 3 steps, period 20, dir 1.
    run_move(3, 20, 1'b1, 0);
    check("idle_busy", int'(r_busy_out), 0);

    // Period below the floor is clamped to 2*PW.
    run_move(2, 3, 1'b0, 0);

    // Zero steps: done pulse only, dir and count untouched.
    run_move(0, 20, 1'b1, 0);
    check("zero_steps_busy", int'(r_busy_out), 0);

    // Abort in the second cycle of the third pulse: that pulse completes, 7 remain.
    run_move(10, 20, 1'b1, DS + 2 * 20 + 2);
    check("abort_remaining", int'(r_remaining_out), 7);

    // Abort together with start in IDLE: no move starts.
    @(negedge clk_in);
    start_in = 1'b1; abort_in = 1'b1; dir_in = 1'b0; steps_in = CW'(3); period_in = PWID'(10);
    @(negedge clk_in);
    start_in = 1'b0; abort_in = 1'b0;
    repeat (10) @(negedge clk_in);
    check("abort_start_busy", int'(r_busy_out), 0);
    check("abort_start_dir", int'(dir_out), int'(mdl_dir));

    // Start with dir 0 while busy: ignored.
    begin_move(4, 12, 1'b1, 0, 1'b0, c, ab, end_e);
    while (cyc < c + 10) @(negedge clk_in);
    start_in = 1'b1; dir_in = 1'b0; steps_in = CW'(5);
    @(negedge clk_in);
    start_in = 1'b0;
    finish_move(ab, end_e);

    // Reset in the middle of the second pulse, then a normal move straight after release.
    begin_move(4, 20, 1'b1, 0, 1'b0, c, ab, end_e);
    while (cyc < c + DS + 20 + 1) @(negedge clk_in);
    #2;
    check("pre_reset_step_out", int'(step_out), 1);
    reset_in = 1'b1;
    #1;
    check_reset_values("mid_pulse_reset");
    exp_q.delete();
    mdl_dir = 1'b0;
    mdl_rem = 0;
    @(negedge clk_in);
    begin_move(3, 10, 1'b1, 0, 1'b1, c, ab, end_e);
    finish_move(ab, end_e);

    // Randomized moves, some with an abort at a random point.
    for (int i = 0; i < 25; i++) begin
      n      = $urandom_range(0, 5);
      p      = $urandom_range(0, 30);
      d      = 1'($urandom_range(0, 1));
      eff    = (p > 2 * PW) ? p : 2 * PW;
      ab_off = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, DS + n * eff) : 0;
      run_move(n, p, d, ab_off);
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_in);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
